// File: rtl/tt_axi_pkg.sv
// Shared constants and FSM state types for the times-table AXI4-Lite slave.
package tt_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOT_AW,
    W_GOT_W,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/tt_lookup.sv
// Combinational 3-bit x 3-bit unsigned multiply; result fits in 6 bits (max 49).
module tt_lookup (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [5:0] p
);

  // Zero-extend both operands so the product is computed at full 6-bit width.
  always_comb begin
    p = {3'b000, a} * {3'b000, b};
  end

endmodule

// File: rtl/tt_axi_slave.sv
// AXI4-Lite read-only slave returning a*b for operands encoded in the address.
// Writes are accepted and always answered with SLVERR.
module tt_axi_slave
  import tt_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  rd_state_t   rd_state;
  wr_state_t   wr_state;
  logic [5:0]  prod;
  logic        rd_err;
  logic        aw_hs;
  logic        w_hs;

  // Write address and data are never stored.
  logic        unused_wr_inputs;
  assign unused_wr_inputs = ^{awaddr, wdata};

  tt_lookup u_lookup (
    .a (araddr[7:5]),
    .b (araddr[4:2]),
    .p (prod)
  );

  // Unaligned addresses or any set bit above the table window are errors.
  always_comb begin
    rd_err = (araddr[1:0] != 2'b00) || ((araddr >> 8) != '0);
  end

  // Read channel: capture product at AR handshake, hold until R handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            rd_state <= R_RESP;
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rdata    <= rd_err ? '0 : {{(DATA_W-6){1'b0}}, prod};
            rresp    <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            arready  <= 1'b1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rd_state <= R_IDLE;
            rvalid   <= 1'b0;
            arready  <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
  end

  // Write channel: collect AW and W in any order, then issue one SLVERR response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state <= W_RESP;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= RESP_SLVERR;
          end else if (aw_hs) begin
            wr_state <= W_GOT_AW;
            awready  <= 1'b0;
            wready   <= 1'b1;
          end else if (w_hs) begin
            wr_state <= W_GOT_W;
            awready  <= 1'b1;
            wready   <= 1'b0;
          end else begin
            awready  <= 1'b1;
            wready   <= 1'b1;
          end
        end
        W_GOT_AW: begin
          if (w_hs) begin
            wr_state <= W_RESP;
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= RESP_SLVERR;
          end
        end
        W_GOT_W: begin
          if (aw_hs) begin
            wr_state <= W_RESP;
            awready  <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= RESP_SLVERR;
          end
        end
        W_RESP: begin
          if (bready) begin
            wr_state <= W_IDLE;
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_axi_slave.sv
// Randomised scoreboard bench for tt_axi_slave.
module tb_tt_axi_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_rdata_q[$];
  logic [1:0]  exp_rresp_q[$];
  logic [1:0]  exp_bresp_q[$];

  tt_axi_slave #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: table entry is row*col with row = addr/32, col = (addr/4)%8.
  task automatic push_read(input logic [7:0] addr);
    int unsigned ai;
    ai = addr;
    if (ai % 4 != 0) begin
      exp_rdata_q.push_back(32'd0);
      exp_rresp_q.push_back(2'b10);
    end else begin
      exp_rdata_q.push_back(32'((ai / 32) * ((ai / 4) % 8)));
      exp_rresp_q.push_back(2'b00);
    end
  endtask

  // Monitor: an R or B beat is consumed at the edge following a negedge with valid&ready.
  always @(negedge clk) begin
    if (rst) begin
      if (rvalid && rready) begin
        if (exp_rdata_q.size() == 0) begin
          check("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          check("rdata", rdata, exp_rdata_q.pop_front());
          check("rresp", 32'(rresp), 32'(exp_rresp_q.pop_front()));
        end
      end
      if (bvalid && bready) begin
        if (exp_bresp_q.size() == 0) begin
          check("unexpected_bvalid", 32'd1, 32'd0);
        end else begin
          check("bresp", 32'(bresp), 32'(exp_bresp_q.pop_front()));
        end
      end
    end
  end

  task automatic rd(input logic [7:0] addr, input int stall);
    bit ok;
    logic [31:0] held;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1; rready = (stall == 0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("ar_timeout", 32'd1, 32'd0);
      arvalid = 1'b0;
      return;
    end
    push_read(addr);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rvalid_latency", 32'(rvalid), 32'd1);
    check("arready_busy", 32'(arready), 32'd0);
    held = rdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("bp_rvalid", 32'(rvalid), 32'd1);
      check("bp_arready", 32'(arready), 32'd0);
      check("bp_rdata_stable", rdata, held);
    end
    if (stall != 0) begin
      @(posedge clk); #1;
      rready = 1'b1;
    end
    @(posedge clk); #1;
    check("rvalid_drop", 32'(rvalid), 32'd0);
    check("arready_back", 32'(arready), 32'd1);
    rready = 1'b0;
  endtask

  task automatic wait_aw();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready) begin @(posedge clk); #1; awvalid = 1'b0; return; end
    end
    check("aw_timeout", 32'd1, 32'd0);
    awvalid = 1'b0;
  endtask

  task automatic wait_w();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wready) begin @(posedge clk); #1; wvalid = 1'b0; return; end
    end
    check("w_timeout", 32'd1, 32'd0);
    wvalid = 1'b0;
  endtask

  // mode 0: AW two cycles before W; 1: W before AW; 2: both together.
  task automatic wr(input int mode);
    @(posedge clk); #1;
    awaddr = 8'($urandom); wdata = $urandom;
    exp_bresp_q.push_back(2'b10);
    case (mode)
      0: begin
        awvalid = 1'b1; wait_aw();
        @(posedge clk); #1; @(posedge clk); #1;
        wvalid = 1'b1; wait_w();
      end
      1: begin
        wvalid = 1'b1; wait_w();
        @(posedge clk); #1;
        awvalid = 1'b1; wait_aw();
      end
      default: begin
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 50 && (awvalid || wvalid); i++) begin
          @(negedge clk);
          if (awready && wready) begin @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; end
        end
        if (awvalid || wvalid) begin
          check("aw_w_timeout", 32'd1, 32'd0);
          awvalid = 1'b0; wvalid = 1'b0;
        end
      end
    endcase
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned order[64];
    rst = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {arready, awready, wready, rvalid, bvalid, rresp, bresp},  32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {29'd0, arready, awready, wready}, 32'd7);

    rd(8'h7C, 0);
    rd(8'hE8, 5);
    rd(8'h7D, 0);

    for (int i = 0; i < 64; i++) order[i] = i;
    for (int i = 63; i > 0; i--) begin
      int unsigned j;
      int unsigned t;
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 64; i++) rd(8'(order[i] * 4), int'($urandom_range(2, 0)));
    for (int i = 0; i < 20; i++) rd(8'($urandom), int'($urandom_range(3, 0)));

    for (int m = 0; m < 3; m++) begin
      fork
        wr(m);
        rd(8'h24, 1);
      join
    end

    // Abort a pending response with reset.
    @(posedge clk); #1;
    araddr = 8'h30; arvalid = 1'b1; rready = 1'b0;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (arready) begin ok = 1'b1; break; end
      end
      if (!ok) check("abort_ar_timeout", 32'd1, 32'd0);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("abort_rvalid_set", 32'(rvalid), 32'd1);
    #2 rst = 1'b0;
    #1 check("async_rvalid_clear", 32'(rvalid), 32'd0);
    check("async_arready_clear", 32'(arready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_rvalid", 32'(rvalid), 32'd0);
    end
    rready = 1'b0;
    rd(8'h48, 0);

    repeat (4) @(posedge clk);
    check("rd_queue_drained", 32'(exp_rdata_q.size()), 32'd0);
    check("b_queue_drained", 32'(exp_bresp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tt_axi_slave.md
# tt_axi_slave

AXI4-Lite slave that serves the 8x8 times table to the AXI multiplier front end, sitting directly downstream of it on the AXI bus. Each aligned read returns the 6-bit product of two 3-bit operands encoded in the address, zero-extended to the data width. The table is read-only: write transactions are fully handshaked and answered with SLVERR. One outstanding read and one outstanding write at a time; the two channels are independent.

## Interface
- ADDR_W, 8, address width in bits (byte addressing)
- DATA_W, 32, data width in bits
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- araddr  in  ADDR_W  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  ADDR_W  write address (ignored beyond handshake)
- awvalid / awready  in / out  1  write address handshake
- wdata  in  DATA_W  write data (discarded)
- wvalid / wready  in / out  1  write data handshake
- bresp  out  2  write response
- bvalid / bready  out / in  1  write response handshake

## Operation
- Address decode: word index = araddr[7:2]; a = araddr[7:5], b = araddr[4:2]. Bits above 7 (ADDR_W > 8) must be zero, otherwise the read is an error.
- Read data: rdata = {(DATA_W-6) zeros, a*b}. Product is 6 bits unsigned; max 7*7 = 49.
- Error read: araddr[1:0] != 0 or nonzero high bits -> rresp = SLVERR (2'b10), rdata = 0.
- Read FSM: R_IDLE (arready=1) -> AR handshake -> R_RESP (rvalid=1, rdata/rresp held stable) -> R handshake -> R_IDLE.
- Write FSM: W_IDLE (awready=wready=1); AW and W are accepted in either order or in the same cycle. States W_IDLE, W_GOT_AW (wready=1 only), W_GOT_W (awready=1 only), W_RESP (bvalid=1, bresp=SLVERR). B handshake -> W_IDLE.
- Read and write channels operate concurrently with no interaction.

## Timing
- Reset (rst=0, asynchronous): arready=awready=wready=0, rvalid=bvalid=0, rdata=0, rresp=bresp=0, both FSMs in idle. At the first rising edge with rst=1, arready, awready and wready go to 1.
- Read latency: AR handshake at edge N -> rvalid=1 with valid rdata after edge N; arready=0 after edge N.
- rvalid stays high with stable rdata/rresp until rready is sampled high. After that edge, rvalid=0 and arready=1. The next AR can be accepted at the following edge, so the minimum spacing is 2 cycles per read.
- Write: the edge that completes the second of AW/W (or both together) sets bvalid=1 and drops the remaining ready. The B handshake edge sets bvalid=0 and awready=wready=1.
- arvalid held high across a completed read does not start a new read until arready=1 is observed at an edge.
- Reset asserted mid-transaction aborts it immediately. No response is issued after reset is released.

## Structure
- Package tt_axi_pkg holds RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, plus the read and write FSM state encodings.
- Sub-module tt_lookup: combinational 3-bit x 3-bit -> 6-bit product, instantiated once. The data register in tt_axi_slave captures its output at the AR handshake.

## Test plan
- Reset release: hold rst=0 for 3 cycles -> all outputs 0. One edge after release -> arready=awready=wready=1.
- Read araddr=8'h7C (a=3, b=7) with rready=1 -> rvalid=1 one cycle after the handshake, rdata=21, rresp=OKAY. Sweep all 64 aligned addresses against a*b (including 0x00 -> 0 and 0xFC -> 49).
- Backpressure: read araddr=8'hE8 (a=7, b=2) with rready=0 for 5 cycles -> rvalid held, rdata=14 stable, arready=0 throughout. Release rready -> rvalid=0 and arready=1 next edge.
- Unaligned read araddr=8'h7D -> rresp=SLVERR, rdata=0.
- Write with AW 2 cycles before W, then W before AW, then AW and W simultaneous, with bready=1 -> bvalid=1 exactly once per write, bresp=SLVERR. A concurrent read of 0x24 (a=1, b=1) returns 1 unaffected.
- Assert rst while rvalid=1 -> rvalid=0 immediately (asynchronously). After release, no stale response appears and a new read of 0x48 (a=2, b=2) returns 4.
